// File: rtl/md5_cmd_parser.sv
// Host command framer between the UART and the md5 core: loads the target hash,
// streams candidate strings and queues one-byte ACK/NAK responses to the transmitter.
module md5_cmd_parser #(
  parameter int MAX_LEN        = 55,
  parameter int TIMEOUT_CYCLES = 9600
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_data_ready,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [127:0] target_hash,
  output logic         target_valid,
  output logic [7:0]   msg_data,
  output logic         msg_valid,
  output logic         msg_last,
  input  logic         msg_ready,
  output logic         msg_abort,
  output logic         err_sticky
);

  localparam logic [7:0] CMD_SET_HASH = 8'h01;
  localparam logic [7:0] CMD_SEND_STR = 8'h02;
  localparam logic [7:0] CMD_PING     = 8'h03;
  localparam logic [7:0] RSP_NAK      = 8'hEE;
  localparam int         TW           = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HASH,
    S_LEN,
    S_STR,
    S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic [7:0]     len_q, len_d;
  logic [119:0]   shadow_q, shadow_d;
  logic [127:0]   target_hash_q, target_hash_d;
  logic           target_valid_q, target_valid_d;
  logic           hold_valid_q, hold_valid_d;
  logic [7:0]     hold_data_q, hold_data_d;
  logic           hold_last_q, hold_last_d;
  logic           msg_abort_q, msg_abort_d;
  logic           err_q;
  logic           err_set;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           tmo_fire;
  logic           rsp_push;
  logic [7:0]     rsp_data;

  // Response FIFO: two entries, pointer-addressed
  logic [7:0]     fifo_mem_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     count_q;
  logic [1:0]     start_hist_q;
  logic           fifo_wr, fifo_pop, fifo_drop;

  assign fifo_pop  = (count_q != 2'd0) && !tx_busy && (start_hist_q == 2'b00);
  assign fifo_wr   = rsp_push && ((count_q != 2'd2) || fifo_pop);
  assign fifo_drop = rsp_push && !fifo_wr;

  assign tx_start     = fifo_pop;
  assign tx_data      = fifo_pop ? fifo_mem_q[rd_ptr_q] : 8'h00;
  assign target_hash  = target_hash_q;
  assign target_valid = target_valid_q;
  assign msg_data     = hold_data_q;
  assign msg_valid    = hold_valid_q;
  assign msg_last     = hold_valid_q & hold_last_q;
  assign msg_abort    = msg_abort_q;
  assign err_sticky   = err_q;

  // Timeout only runs while a command is partially received
  assign tmo_fire = (state_q == S_HASH || state_q == S_LEN || state_q == S_STR) &&
                    !rx_data_ready && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    len_d          = len_q;
    shadow_d       = shadow_q;
    target_hash_d  = target_hash_q;
    target_valid_d = 1'b0;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    hold_last_d    = hold_last_q;
    msg_abort_d    = 1'b0;
    err_set        = 1'b0;
    rsp_push       = 1'b0;
    rsp_data       = 8'h00;
    tmo_cnt_d      = '0;

    if (state_q == S_HASH || state_q == S_LEN || state_q == S_STR) begin
      tmo_cnt_d = rx_data_ready ? '0 : tmo_cnt_q + 1'b1;
    end

    if (hold_valid_q && msg_ready) begin
      hold_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_data_ready) begin
          case (rx_data)
            CMD_SET_HASH: begin
              state_d    = S_HASH;
              byte_cnt_d = 8'd0;
            end
            CMD_SEND_STR: state_d = S_LEN;
            CMD_PING: begin
              rsp_push = 1'b1;
              rsp_data = CMD_PING;
            end
            default: begin
              rsp_push = 1'b1;
              rsp_data = RSP_NAK;
              err_set  = 1'b1;
            end
          endcase
        end
      end

      S_HASH: begin
        if (rx_data_ready) begin
          shadow_d   = {shadow_q[111:0], rx_data};
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_q == 8'd15) begin
            // Whole hash is committed at once so target_hash never shows a partial load
            target_hash_d  = {shadow_q, rx_data};
            target_valid_d = 1'b1;
            rsp_push       = 1'b1;
            rsp_data       = CMD_SET_HASH;
            state_d        = S_IDLE;
          end
        end else if (tmo_fire) begin
          rsp_push = 1'b1;
          rsp_data = RSP_NAK;
          err_set  = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_LEN: begin
        if (rx_data_ready) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            rsp_push = 1'b1;
            rsp_data = RSP_NAK;
            err_set  = 1'b1;
            state_d  = S_IDLE;
          end else begin
            len_d      = rx_data;
            byte_cnt_d = 8'd0;
            state_d    = S_STR;
          end
        end else if (tmo_fire) begin
          rsp_push = 1'b1;
          rsp_data = RSP_NAK;
          err_set  = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_STR: begin
        if (rx_data_ready) begin
          // A byte freed by a handshake in this same cycle is not an overflow
          if (hold_valid_q && !msg_ready) begin
            hold_valid_d = 1'b0;
            hold_data_d  = 8'h00;
            hold_last_d  = 1'b0;
            msg_abort_d  = 1'b1;
            rsp_push     = 1'b1;
            rsp_data     = RSP_NAK;
            err_set      = 1'b1;
            state_d      = S_IDLE;
          end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = rx_data;
            hold_last_d  = (byte_cnt_q + 8'd1 == len_q);
            byte_cnt_d   = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == len_q) begin
              state_d = S_DRAIN;
            end
          end
        end else if (tmo_fire) begin
          hold_valid_d = 1'b0;
          hold_data_d  = 8'h00;
          hold_last_d  = 1'b0;
          msg_abort_d  = 1'b1;
          rsp_push     = 1'b1;
          rsp_data     = RSP_NAK;
          err_set      = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (!hold_valid_q || msg_ready) begin
          rsp_push = 1'b1;
          rsp_data = CMD_SEND_STR;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= 8'd0;
      len_q          <= 8'd0;
      shadow_q       <= '0;
      target_hash_q  <= '0;
      target_valid_q <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= 8'h00;
      hold_last_q    <= 1'b0;
      msg_abort_q    <= 1'b0;
      err_q          <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      len_q          <= len_d;
      shadow_q       <= shadow_d;
      target_hash_q  <= target_hash_d;
      target_valid_q <= target_valid_d;
      hold_valid_q   <= hold_valid_d;
      hold_data_q    <= hold_data_d;
      hold_last_q    <= hold_last_d;
      msg_abort_q    <= msg_abort_d;
      err_q          <= err_q | err_set | fifo_drop;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (reset) begin
        fifo_mem_q[gi] <= 8'h00;
      end else if (fifo_wr && (wr_ptr_q == 1'(gi))) begin
        fifo_mem_q[gi] <= rsp_data;
      end
    end
  end

  // start_hist_q blocks a new start for two cycles while tx_busy catches up
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      start_hist_q <= 2'b00;
    end else begin
      if (fifo_wr) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q      <= count_q + {1'b0, fifo_wr} - {1'b0, fifo_pop};
      start_hist_q <= {start_hist_q[0], fifo_pop};
    end
  end

endmodule

// File: tb/tb_md5_cmd_parser.sv
// Directed bench for md5_cmd_parser: PING, SET_HASH, SEND_STR, overflow,
// bad length, timeout, response backpressure and reset mid-string.
module tb_md5_cmd_parser;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_data_ready;
  logic [7:0]   rx_data;
  logic         tx_busy;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [127:0] target_hash;
  logic         target_valid;
  logic [7:0]   msg_data;
  logic         msg_valid;
  logic         msg_last;
  logic         msg_ready;
  logic         msg_abort;
  logic         err_sticky;

  md5_cmd_parser #(.MAX_LEN(55), .TIMEOUT_CYCLES(9600)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .target_hash   (target_hash),
    .target_valid  (target_valid),
    .msg_data      (msg_data),
    .msg_valid     (msg_valid),
    .msg_last      (msg_last),
    .msg_ready     (msg_ready),
    .msg_abort     (msg_abort),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tv_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  logic [7:0] hs_data[$];
  logic       hs_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observers sample half a cycle away from the active edge
  always @(negedge clk) begin
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
      $display("[%0t] tx byte %02h", $time, tx_data);
    end
    if (target_valid) tv_cnt = tv_cnt + 1;
    if (msg_abort) abort_cnt = abort_cnt + 1;
    if (msg_valid && msg_ready) begin
      hs_data.push_back(msg_data);
      hs_last.push_back(msg_last);
      $display("[%0t] msg byte %02h last=%0b", $time, msg_data, msg_last);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      $display("[%0t] check %s ok (%0h)", $time, tag, obs);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data_ready = 1'b1;
    rx_data       = b;
    @(posedge clk); #1;
    rx_data_ready = 1'b0;
    rx_data       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int tb, tvb, hb, ab;

  initial begin
    reset = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; msg_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_target_hash", target_hash, 0);
    chk("rst_target_valid", target_valid, 0);
    chk("rst_msg_data", msg_data, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_msg_last", msg_last, 0);
    chk("rst_msg_abort", msg_abort, 0);
    chk("rst_err", err_sticky, 0);
    @(posedge clk); #1 reset = 1'b0;

    // PING
    tb = tx_log.size(); tvb = tv_cnt; hb = hs_data.size(); ab = abort_cnt;
    send(8'h03);
    idle(10);
    chk("ping_count", tx_log.size() - tb, 1);
    chk("ping_data", tx_log[tb], 8'h03);
    chk("ping_tv", tv_cnt - tvb, 0);
    chk("ping_msg", hs_data.size() - hb, 0);
    chk("ping_abort", abort_cnt - ab, 0);
    chk("ping_err", err_sticky, 0);

    // SET_HASH, first 15 bytes must not reach target_hash
    tb = tx_log.size(); tvb = tv_cnt;
    send(8'h01);
    for (int i = 0; i < 15; i++) send(8'(i));
    idle(5);
    chk("hash_partial", target_hash, 0);
    chk("hash_partial_tv", tv_cnt - tvb, 0);
    chk("hash_partial_rsp", tx_log.size() - tb, 0);
    send(8'h0F);
    chk("hash_tv_pulse", target_valid, 1);
    chk("hash_value", target_hash, 128'h000102030405060708090A0B0C0D0E0F);
    idle(10);
    chk("hash_tv_count", tv_cnt - tvb, 1);
    chk("hash_tv_low", target_valid, 0);
    chk("hash_rsp_count", tx_log.size() - tb, 1);
    chk("hash_rsp", tx_log[tb], 8'h01);

    // SEND_STR "abc" with msg_ready high
    tb = tx_log.size(); hb = hs_data.size(); ab = abort_cnt;
    send(8'h02); send(8'h03); send(8'h61); send(8'h62); send(8'h63);
    idle(10);
    chk("str_hs_count", hs_data.size() - hb, 3);
    chk("str_b0", hs_data[hb], 8'h61);
    chk("str_b1", hs_data[hb+1], 8'h62);
    chk("str_b2", hs_data[hb+2], 8'h63);
    chk("str_last0", hs_last[hb], 0);
    chk("str_last1", hs_last[hb+1], 0);
    chk("str_last2", hs_last[hb+2], 1);
    chk("str_rsp_count", tx_log.size() - tb, 1);
    chk("str_rsp", tx_log[tb], 8'h02);
    chk("str_abort", abort_cnt - ab, 0);
    chk("str_err", err_sticky, 0);

    // Overflow: msg_ready low, second string byte arrives while held
    msg_ready = 1'b0;
    tb = tx_log.size(); ab = abort_cnt;
    send(8'h02); send(8'h05); send(8'h41);
    idle(2);
    chk("ovf_held_valid", msg_valid, 1);
    chk("ovf_held_data", msg_data, 8'h41);
    send(8'h42);
    idle(5);
    chk("ovf_abort", abort_cnt - ab, 1);
    chk("ovf_rsp_count", tx_log.size() - tb, 1);
    chk("ovf_rsp", tx_log[tb], 8'hEE);
    chk("ovf_err", err_sticky, 1);
    chk("ovf_valid_clr", msg_valid, 0);
    msg_ready = 1'b1;

    // Zero length
    tb = tx_log.size();
    send(8'h02); send(8'h00);
    idle(10);
    chk("len0_rsp_count", tx_log.size() - tb, 1);
    chk("len0_rsp", tx_log[tb], 8'hEE);
    tb = tx_log.size();
    send(8'h03);
    idle(10);
    chk("len0_idle_ping", tx_log[tb], 8'h03);

    // Timeout inside SET_HASH
    do_reset();
    idle(1);
    chk("tmo_err_pre", err_sticky, 0);
    tb = tx_log.size();
    send(8'h01);
    for (int i = 0; i < 5; i++) send(8'hAA);
    idle(9000);
    chk("tmo_early", tx_log.size() - tb, 0);
    for (int i = 0; i < 2000 && tx_log.size() == tb; i++) @(negedge clk);
    chk("tmo_rsp_count", tx_log.size() - tb, 1);
    chk("tmo_rsp", tx_log[tb], 8'hEE);
    chk("tmo_err", err_sticky, 1);
    chk("tmo_hash_kept", target_hash, 0);
    tb = tx_log.size();
    send(8'h03);
    idle(10);
    chk("tmo_ping_count", tx_log.size() - tb, 1);
    chk("tmo_ping", tx_log[tb], 8'h03);

    // Response backpressure: third PING dropped
    do_reset();
    tx_busy = 1'b1;
    tb = tx_log.size();
    send(8'h03); send(8'h03); send(8'h03);
    idle(10);
    chk("bp_none_while_busy", tx_log.size() - tb, 0);
    chk("bp_err", err_sticky, 1);
    @(posedge clk); #1 tx_busy = 1'b0;
    idle(20);
    chk("bp_count", tx_log.size() - tb, 2);
    chk("bp_rsp0", tx_log[tb], 8'h03);
    chk("bp_rsp1", tx_log[tb+1], 8'h03);
    chk("bp_guard_gap", tx_cyc[tb+1] - tx_cyc[tb], 3);

    // Reset in the middle of a string
    do_reset();
    msg_ready = 1'b0;
    ab = abort_cnt;
    send(8'h02); send(8'h04); send(8'h61);
    idle(2);
    chk("mid_held", msg_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", msg_valid, 0);
    chk("mid_rst_data", msg_data, 0);
    chk("mid_rst_abort", msg_abort, 0);
    chk("mid_rst_tx", tx_start, 0);
    chk("mid_rst_err", err_sticky, 0);
    @(posedge clk); #1 reset = 1'b0;
    idle(5);
    chk("mid_no_abort", abort_cnt - ab, 0);
    chk("mid_valid_after", msg_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_cmd_parser.md
Name: md5_cmd_parser

Overview:
- Command framer directly downstream of the UART receiver (async_receiver) and upstream of the transmitter (async_transmitter); replaces the current rx-to-tx loopback.
- Parses host byte commands, loads the 128-bit target hash, and streams candidate-string bytes to the md5 core.
- Queues one-byte ACK/NAK responses back to the transmitter.

Parameters:
- MAX_LEN, 55, maximum string length in bytes for SEND_STR (a single md5 block).
- TIMEOUT_CYCLES, 9600, idle cycles allowed between bytes inside a command before it is aborted (100 us at 96 MHz).

Ports:
- clk  in  1  system clock (96 MHz domain)
- reset  in  1  synchronous, active-high reset
- rx_data_ready  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  transmitter busy
- tx_start  out  1  one-cycle strobe to start a byte transmission
- tx_data  out  8  byte to transmit, valid while tx_start=1
- target_hash  out  128  loaded hash; first received byte lands in [127:120]
- target_valid  out  1  one-cycle pulse when target_hash updates
- msg_data  out  8  string byte to md5 core
- msg_valid  out  1  msg_data valid
- msg_last  out  1  qualifies final byte of a string
- msg_ready  in  1  core accepts byte when msg_valid & msg_ready
- msg_abort  out  1  one-cycle pulse: current string discarded
- err_sticky  out  1  set on any protocol error, cleared only by reset

Behaviour:
- Reset values: all outputs 0, target_hash 0, state IDLE, response FIFO empty, holding register empty. A reset mid-command discards everything without emitting msg_abort.
- Commands (first byte):
  - 0x01 SET_HASH: followed by 16 bytes.
  - 0x02 SEND_STR: followed by length L, then L bytes.
  - 0x03 PING: no payload.
- States: IDLE, HASH (byte counter 0..15), LEN, STR (byte counter), DRAIN.
- IDLE:
  - 0x01 -> HASH.
  - 0x02 -> LEN.
  - 0x03 -> queue 0x03, stay in IDLE.
  - Any other byte -> queue NAK 0xEE, set err_sticky, stay in IDLE.
- HASH:
  - Bytes shift into a shadow register.
  - On the 16th byte: the shadow is copied to target_hash on the next cycle with target_valid=1 that same cycle, ACK 0x01 is queued, and the state returns to IDLE.
  - target_hash never shows partial data.
- LEN:
  - L=0 or L>MAX_LEN -> NAK 0xEE, err_sticky, IDLE.
  - Otherwise latch L -> STR.
- STR:
  - Each byte goes into a 1-entry holding register driving msg_data/msg_valid.
  - msg_last=1 when the held byte is byte L.
  - The register empties on msg_valid&msg_ready.
  - A byte arriving while the register is still full is an overflow: drop the byte, clear the holding register, pulse msg_abort, NAK 0xEE, err_sticky, IDLE.
  - After byte L is received -> DRAIN.
- DRAIN: wait for the last byte to be accepted, then queue ACK 0x02 -> IDLE.
- Timeout:
  - Counter resets on every rx_data_ready and counts only in HASH/LEN/STR.
  - When it reaches TIMEOUT_CYCLES: NAK 0xEE, err_sticky, IDLE.
  - msg_abort pulses if in STR, and the holding register clears.
  - DRAIN has no timeout.
- Response FIFO:
  - 2 entries.
  - If full when a response is queued, the new response is dropped and err_sticky is set.
  - If queue and pop happen in the same cycle, both take effect.
- TX handshake:
  - When the FIFO is non-empty, tx_busy=0 and no start was issued in the previous 2 cycles: assert tx_start for 1 cycle with tx_data = FIFO head, and pop.
  - The 2-cycle guard covers the transmitter's busy latency.
- rx_data_ready is processed in the same cycle it is seen; there are no back-to-back stalls on the rx side.

Test Plan:
- PING: send 0x03 -> exactly one tx_start with tx_data=0x03; no other outputs change.
- SET_HASH: send 0x01 followed by bytes 0x00..0x0F -> target_valid one pulse, target_hash=128'h000102030405060708090A0B0C0D0E0F, response 0x01; after only 15 bytes, target_hash is still unchanged.
- SEND_STR with msg_ready=1: send 0x02,0x03,"a","b","c" -> msg_data 0x61,0x62,0x63 handshaked, msg_last only on 0x63, then response 0x02.
- Overflow and bad length:
  - msg_ready=0 during SEND_STR, two string bytes arrive -> msg_abort pulse, response 0xEE, err_sticky=1.
  - Then send 0x02,0x00 -> response 0xEE, state IDLE.
- Timeout: send 0x01 plus 5 bytes, then silence for 9600 cycles -> response 0xEE, err_sticky=1; a following PING still returns 0x03.
- Response backpressure: hold tx_busy=1 and send PING x3 -> two 0x03 responses after tx_busy falls, third dropped, err_sticky=1; reset mid-STR -> all outputs 0, no msg_abort.
